salu_instr_issue: RTL and testbench

SALU_INSTR_ISSUE -- requirements
Module: salu_instr_issue

---
 rtl/salu_instr_pkg.sv | 13 +
 rtl/valid_intr.sv | 11 +
 rtl/salu_issue_fifo.sv | 51 +++++
 rtl/salu_instr_issue.sv | 161 ++++++++++++++++
 tb/tb_salu_instr_issue.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/salu_instr_pkg.sv
// Shared types and constants for the SALU instruction issue unit.
// Holds the issue state encoding and the fetch address stride.
package salu_instr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT
    } issue_state_e;

    localparam int INSTR_STRIDE = 4;

endpackage

// File: rtl/valid_intr.sv
// Valid-only instruction channel toward the SOP/SOPK decoders.
// The sink has no ready; backpressure travels on a separate stall line.
interface valid_intr;

    logic        valid;
    logic [31:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);

endinterface

// File: rtl/salu_issue_fifo.sv
// Synchronous prefetch FIFO with flush and occupancy count.
// Pointers carry one extra wrap bit so full and empty need no counter.
module salu_issue_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic          full;
    logic [W-1:0]  mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + CW'(1);
            if (pop && !empty)
                rptr <= rptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/salu_instr_issue.sv
// SALU fetch/issue front end: credit-limited prefetch into a small FIFO.
// Optional perf counters are enabled with SALU_ISSUE_PERF_EN.
module salu_instr_issue
    import salu_instr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              issue_stall,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    valid_intr.master         instr,
    output logic              busy
`ifdef SALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall
`endif
);

    localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    issue_state_e      state;
    issue_state_e      state_nx;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard_cnt;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       fifo_head;
    logic              fifo_empty;
    logic [CW:0]       credit;
    logic              in_fetch;
    logic              go_halt;
    logic              go_redir;
    logic              flush;
    logic              req_fire;
    logic              rsp_fire;
    logic              push;
    logic              pop;
    logic              start_ok;

    assign in_fetch = (state == ST_FETCH);
    assign start_ok = (state == ST_IDLE) && start;
    assign go_halt  = in_fetch && halt_req;
    assign go_redir = in_fetch && redirect_valid && !halt_req;
    assign flush    = go_halt || go_redir || (state == ST_HALT);
    assign credit   = {1'b0, outstanding} + {1'b0, fifo_count};

    // Never request more than the FIFO can still absorb.
    assign imem_req_valid = in_fetch && !redirect_valid && !halt_req &&
                            (credit < CREDIT_MAX);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
    assign push           = rsp_fire && in_fetch && !flush &&
                            (discard_cnt == '0);
    assign pop            = in_fetch && !flush && !fifo_empty && !issue_stall;
    assign busy           = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_FETCH;
            ST_FETCH: if (halt_req) state_nx = ST_HALT;
            ST_HALT:  if (outstanding == '0) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (start_ok)
            pc <= start_pc;
        else if (go_redir)
            pc <= redirect_pc;
        else if (req_fire)
            pc <= pc + ADDR_W'(INSTR_STRIDE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outstanding <= '0;
        else
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
    end

    // Responses already in flight at a redirect belong to the old path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            discard_cnt <= '0;
        else if (go_redir)
            discard_cnt <= outstanding - CW'(rsp_fire);
        else if (go_halt || state != ST_FETCH)
            discard_cnt <= '0;
        else if (rsp_fire && discard_cnt != '0)
            discard_cnt <= discard_cnt - CW'(1);
    end

    salu_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (imem_rsp_data),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr.valid <= 1'b0;
            instr.data  <= '0;
        end else begin
            instr.valid <= pop;
            if (pop)
                instr.data <= fifo_head;
        end
    end

`ifdef SALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (start_ok) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (instr.valid)
                perf_issued <= perf_issued + 32'd1;
            if (!fifo_empty && issue_stall)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_salu_instr_issue.sv
// Randomized bench for salu_instr_issue against a path/epoch reference.
// Memory model answers in order; expected stream is rebuilt from addresses.
module tb_salu_instr_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        issue_stall = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        busy;
`ifdef SALU_ISSUE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    valid_intr instr_if();

    salu_instr_issue #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_pc       (start_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .issue_stall    (issue_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr_if),
        .busy           (busy)
`ifdef SALU_ISSUE_PERF_EN
        ,
        .perf_issued    (perf_issued),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; int ep; int cyc;} mreq_t;
    typedef struct {logic [31:0] addr; int cyc;} rdy_t;
    typedef enum {M_IDLE, M_FETCH, M_HALT} mst_e;

    mreq_t       mem_q[$];
    rdy_t        rdy_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] iss_log[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          ready_pct = 100;
    int          rsp_pct = 100;
    int          halt_wait = 0;
    mst_e        mst = M_IDLE;
    logic [31:0] exp_pc = '0;
    bit          lat_chk = 1'b0;
    bit          quiet = 1'b0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0135_7BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit stl = 0, input bit st = 0,
                        input logic [31:0] spc = 0, input bit rd = 0,
                        input logic [31:0] rpc = 0, input bit hl = 0);
        bit    fire;
        mreq_t m;
        rdy_t  r;
        @(negedge clk);
        cyc++;
        start          = st;
        start_pc       = spc;
        redirect_valid = rd;
        redirect_pc    = rpc;
        halt_req       = hl;
        issue_stall    = stl;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].cyc < cyc &&
            $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mem_q[0].addr);
        end
        #1;
        if (instr_if.valid) begin
            if (quiet)
                check("valid_after_flush", 32'(instr_if.valid), 0);
            if (rdy_q.size() == 0) begin
                check("spurious_issue", 32'(instr_if.valid), 0);
            end else begin
                r = rdy_q.pop_front();
                check("issue_data", instr_if.data, word(r.addr));
                if (lat_chk)
                    check("issue_latency", cyc - r.cyc, 2);
                iss_log.push_back(instr_if.data);
            end
        end
        quiet = 1'b0;
        if (imem_req_valid) begin
            if (mst != M_FETCH || rd || hl)
                check("illegal_req", 32'(imem_req_valid), 0);
            else
                check("req_addr", imem_req_addr, exp_pc);
        end
        case (mst)
            M_IDLE:  if (busy) check("busy_idle", 32'(busy), 0);
            M_FETCH: if (!busy) check("busy_fetch", 32'(busy), 1);
            default: begin
                if (!busy) begin
                    check("halt_drained", mem_q.size(), 0);
                    mst = M_IDLE;
                end else if (mem_q.size() == 0) begin
                    halt_wait++;
                    if (halt_wait > 3)
                        check("halt_exit", 32'(busy), 0);
                end
            end
        endcase
        fire = imem_req_valid && imem_req_ready;
        if (fire) begin
            mem_q.push_back('{imem_req_addr, epoch, cyc});
            acc_log.push_back(imem_req_addr);
            exp_pc = exp_pc + 32'd4;
        end
        if (mst == M_FETCH && (hl || rd)) begin
            epoch++;
            rdy_q.delete();
            quiet = 1'b1;
            if (hl) begin
                mst = M_HALT;
                halt_wait = 0;
            end else begin
                exp_pc = rpc;
            end
        end else if (mst == M_IDLE && st) begin
            mst = M_FETCH;
            exp_pc = spc;
        end
        if (imem_rsp_valid) begin
            m = mem_q.pop_front();
            if (m.ep == epoch && mst == M_FETCH)
                rdy_q.push_back('{m.addr, cyc});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        rsp_pct = 100;
        while (mst != M_IDLE && n < 40) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    task automatic halt_and_idle();
        tick(.hl(1));
        wait_idle();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 0);
        check({tag, "_req_addr"}, imem_req_addr, 0);
        check({tag, "_ivalid"}, 32'(instr_if.valid), 0);
        check({tag, "_idata"}, instr_if.data, 0);
        check({tag, "_busy"}, 32'(busy), 0);
`ifdef SALU_ISSUE_PERF_EN
        check({tag, "_perf_issued"}, perf_issued, 0);
        check({tag, "_perf_stall"}, perf_stall, 0);
`endif
    endtask

    initial begin
        int n_pre;
        #1;
        reset_checks("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // In-order 1-cycle memory, latency of each issued word.
        ready_pct = 100;
        rsp_pct   = 100;
        acc_log.delete();
        iss_log.delete();
        lat_chk = 1'b1;
        tick(.st(1), .spc(32'h100));
        repeat (12) tick();
        lat_chk = 1'b0;
        check("seq_a0", acc_log[0], 32'h100);
        check("seq_a1", acc_log[1], 32'h104);
        check("seq_a2", acc_log[2], 32'h108);
        check("seq_a3", acc_log[3], 32'h10C);
        check("seq_first", iss_log[0], word(32'h100));
        halt_and_idle();
`ifdef SALU_ISSUE_PERF_EN
        check("perf_issued_cnt", perf_issued, iss_log.size());
`endif

        // Long stall: credit limit caps requests at FIFO depth.
        acc_log.delete();
        iss_log.delete();
        tick(.stl(1), .st(1), .spc(32'h500));
        repeat (9) tick(.stl(1));
        check("stall_req_cnt", acc_log.size(), 4);
        check("stall_no_issue", iss_log.size(), 0);
        repeat (15) tick();
        check("stall_i0", iss_log[0], word(32'h500));
        check("stall_i3", iss_log[3], word(32'h50C));
        halt_and_idle();

        // Redirect with three requests in flight.
        acc_log.delete();
        iss_log.delete();
        rsp_pct = 0;
        tick(.st(1), .spc(32'h400));
        repeat (3) tick();
        check("redir_inflight", acc_log.size(), 3);
        rsp_pct = 100;
        tick(.rd(1), .rpc(32'h200));
        repeat (12) tick();
        check("redir_first", iss_log[0], word(32'h200));
        check("redir_new_req", acc_log[3], 32'h200);
        halt_and_idle();

        // Halt and redirect together with two outstanding.
        acc_log.delete();
        iss_log.delete();
        rsp_pct = 0;
        tick(.st(1), .spc(32'h300));
        repeat (2) tick();
        check("halt_outst", acc_log.size(), 2);
        tick(.rd(1), .rpc(32'h700), .hl(1));
        repeat (3) tick();
        check("halt_busy", 32'(busy), 1);
        wait_idle();
        check("halt_no_req", acc_log.size(), 2);
        check("halt_no_issue", iss_log.size(), 0);

        // Address wrap at the top of the space.
        acc_log.delete();
        tick(.st(1), .spc(32'hFFFF_FFF8));
        repeat (6) tick();
        check("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
        check("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
        check("wrap_a2", acc_log[2], 32'h0000_0000);
        halt_and_idle();

        // Random traffic against the reference.
        iss_log.delete();
        ready_pct = 70;
        rsp_pct   = 60;
        for (int i = 0; i < 800; i++) begin
            tick(.stl($urandom_range(2) == 0),
                 .st(mst == M_IDLE || $urandom_range(49) == 0),
                 .spc($urandom & ~32'h3),
                 .rd($urandom_range(24) == 0),
                 .rpc($urandom & ~32'h3),
                 .hl($urandom_range(99) == 0));
        end
        check("rand_progress", 32'(iss_log.size() > 50), 1);
        ready_pct = 100;
        halt_and_idle();

        // Asynchronous reset between edges mid-fetch.
        tick(.st(1), .spc(32'h800));
        repeat (5) tick(.stl(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        reset_checks("arst");
        start = 1'b0;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        issue_stall = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_q.delete();
        rdy_q.delete();
        epoch++;
        mst = M_IDLE;
        quiet = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
